lcd_ctrl: RTL
=============

Name: lcd_ctrl

Overview:
- Timed HD44780-style character LCD controller that consumes the LCD register writes produced by the load-store unit.
- Software writes a command or data byte to the LCD I/O address; the LSU address decode pulses i_cmd_valid with RS and data taken from the store data.
- This block runs the power-on init sequence, buffers one command, and generates the setup/enable/hold/execute timing on the LCD pins.
- It returns a busy/ready status that the LSU read path maps into the LCD register read value.

Parameters:
- CNT_W, 20, width of the phase counter; must hold the largest cycle parameter.
- PWR_CYC, 750000, power-on wait after reset release (15 ms at 50 MHz).
- SETUP_CYC, 4, RS/DATA valid before EN rises.
- PULSE_CYC, 25, EN high time.
- HOLD_CYC, 4, RS/DATA held after EN falls.
- EXEC_CYC, 2500, execution wait for normal commands and data (50 us).
- CLR_CYC, 82000, execution wait for clear (0x01) and home (0x02) commands with rs=0.

Ports:
- i_clk, in, 1, clock.
- i_reset, in, 1, reset; asynchronous, active-high.
- i_cmd_valid, in, 1, command request from the LSU LCD write decode.
- i_cmd_rs, in, 1, register select: 0 = instruction, 1 = data.
- i_cmd_data, in, 8, command or data byte.
- o_cmd_ready, out, 1, command buffer empty; a request is accepted when i_cmd_valid && o_cmd_ready.
- o_busy, out, 1, transfer in progress, init in progress, or buffer occupied.
- o_init_done, out, 1, power-on init sequence complete.
- o_lcd_on, out, 1, LCD power enable.
- o_lcd_en, out, 1, LCD enable strobe.
- o_lcd_rs, out, 1, LCD register select.
- o_lcd_rw, out, 1, LCD read/write; tied to 0 (write only).
- o_lcd_data, out, 8, LCD data bus.

Behaviour:
- Reset (asynchronous): every output is 0 except o_cmd_ready=1 and o_busy=1.
  - The state, the init index and the buffer are all cleared.
  - o_lcd_en drops immediately, including mid-pulse.
  - A buffered command is discarded.
- After reset release:
  - o_lcd_on=1 from the first clock edge onward.
  - The FSM enters PWR_WAIT for PWR_CYC cycles.
- States and transitions:
  - PWR_WAIT -> SETUP, loading the init command at index 0.
  - SETUP (SETUP_CYC cycles) -> PULSE (PULSE_CYC cycles, o_lcd_en=1) -> HOLD (HOLD_CYC cycles) -> EXEC.
  - EXEC lasts CLR_CYC cycles if rs=0 and data is 0x01 or 0x02; otherwise it lasts EXEC_CYC cycles.
  - EXEC exit during init: go to SETUP with the next init command. After index 3, set o_init_done=1 and go to IDLE.
  - EXEC exit after init: go to IDLE.
  - IDLE with the buffer full: pop the buffer into the rs/data output registers and go to SETUP on the next edge.
- Init sequence (rs=0), in order: 0x38 function set, 0x0C display on, 0x01 clear, 0x06 entry mode.
- Phase timing:
  - Each phase lasts exactly its parameter count, which must be >= 1.
  - The counter loads count-1 on phase entry and advances at zero.
- Output registers:
  - o_lcd_rs/o_lcd_data are registered, loaded on SETUP entry, and stable through SETUP, PULSE, HOLD and EXEC.
  - They retain their last values in IDLE.
- Command buffer:
  - One entry; o_cmd_ready = !buf_full.
  - Accepting a command sets buf_full on that edge. It is popped only by IDLE.
  - Commands are accepted in any state, including during init. A command accepted during init is issued after init completes.
  - When full, o_cmd_ready=0; i_cmd_valid is ignored and the command is not latched. Software polls o_busy.
  - Push and pop never occur in the same cycle, since a push requires the buffer to be empty.
- Latency: accepted at edge T in IDLE -> SETUP entered at edge T+1 -> o_lcd_en rises at edge T+1+SETUP_CYC.
- o_busy = (state != IDLE) || buf_full.
- o_init_done stays 1 until the next reset.

Decomposition:
- Shared package lcd_pkg holds:
  - the state enum (PWR_WAIT, SETUP, PULSE, HOLD, EXEC, IDLE);
  - the init command constants and count (4);
  - the LCD I/O register bit positions: [31] on, [10] en, [9] rs, [8] rw, [7:0] data, plus the busy bit position used for LSU readback;
  - the clear/home opcode constants.
- Single module; no sub-module. The phase counter and the init command selection are inline.

Test Plan (PWR_CYC=10, SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2, EXEC_CYC=5, CLR_CYC=20):
1. Release reset and idle -> o_lcd_on=1 after the first edge. EN pulses 4 times, each 3 cycles high, with rs=0 and data 0x38, 0x0C, 0x01, 0x06. The EXEC gap after 0x01 is 20 cycles. o_init_done rises 73 cycles after reset release and o_busy falls.
2. After init, send valid rs=1, data 0x41 for one cycle -> ready=0 for one cycle. EN rises 3 edges after accept with rs=1 and data=0x41. o_busy=1 for 13 cycles, then 0.
3. Back-to-back rs=1 writes 0x48, 0x49, 0x4A with valid held -> 0x48 accepted, 0x49 accepted while 0x48 is in SETUP. 0x4A is held (ready=0) until 0x49 pops in IDLE. The bus shows the three bytes in order, with no loss or duplication.
4. rs=0 writes of 0x01, then 0x80 -> EXEC is 20 cycles after 0x01 and 5 cycles after 0x80. An rs=1 write of 0x01 gets a 5-cycle EXEC.
5. Accept 0x41 during init -> no EN pulse for it until after the 0x06 EXEC ends. It then issues as the first post-init transfer.
6. Assert i_reset mid-PULSE with the buffer full -> en=0, o_init_done=0 and ready=1 immediately, with no clock edge. After release, the full 73-cycle init replays and the discarded buffered command never appears.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD controller: FSM states, init
// sequence, LCD I/O register layout and long-execution opcodes.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_SETUP    = 3'd1,
        ST_PULSE    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_EXEC     = 3'd4,
        ST_IDLE     = 3'd5
    } lcd_state_e;

    localparam int INIT_COUNT = 4;

    localparam logic [7:0] INIT_FUNC_SET  = 8'h38;
    localparam logic [7:0] INIT_DISP_ON   = 8'h0C;
    localparam logic [7:0] INIT_CLEAR     = 8'h01;
    localparam logic [7:0] INIT_ENTRY_MODE = 8'h06;

    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;

    // LCD I/O register layout as seen by the load-store unit.
    localparam int LCD_ON_BIT    = 31;
    localparam int LCD_BUSY_BIT  = 11;
    localparam int LCD_EN_BIT    = 10;
    localparam int LCD_RS_BIT    = 9;
    localparam int LCD_RW_BIT    = 8;
    localparam int LCD_DATA_MSB  = 7;
    localparam int LCD_DATA_LSB  = 0;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = INIT_FUNC_SET;
            2'd1:    init_cmd = INIT_DISP_ON;
            2'd2:    init_cmd = INIT_CLEAR;
            default: init_cmd = INIT_ENTRY_MODE;
        endcase
    endfunction

    // Clear and home need the long execution wait; data writes never do.
    function automatic logic is_long_exec(input logic rs, input logic [7:0] data);
        is_long_exec = !rs && ((data == OP_CLEAR) || (data == OP_HOME));
    endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// Timed character LCD controller: power-on init, one-entry command buffer and
// setup/enable/hold/execute sequencing of the LCD pins.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int CNT_W     = 20,
    parameter int PWR_CYC   = 750000,
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 25,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 2500,
    parameter int CLR_CYC   = 82000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ready,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data,
    output lcd_state_e o_dbg_state
);

    // Handshake: a command transfers on any edge where i_cmd_valid && o_cmd_ready;
    // the requester may drop or change i_cmd_valid freely while o_cmd_ready is low.

    localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(PWR_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYC - 1);
    localparam logic [1:0]       INIT_LAST = 2'(INIT_COUNT - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       init_idx_q, init_idx_d;
    logic             init_done_q, init_done_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             lcd_on_q;
    logic             buf_full_q, buf_rs_q;
    logic [7:0]       buf_data_q;
    logic             push, pop;

    assign push = i_cmd_valid && !buf_full_q;
    assign pop  = (state_q == ST_IDLE) && buf_full_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;

        if (state_q != ST_IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            case (state_q)
                ST_PWR_WAIT: begin
                    state_d    = ST_SETUP;
                    cnt_d      = SETUP_LD;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = init_cmd(2'd0);
                end
                ST_SETUP: begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                end
                ST_PULSE: begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end
                ST_HOLD: begin
                    state_d = ST_EXEC;
                    cnt_d   = is_long_exec(lcd_rs_q, lcd_data_q) ? CLR_LD : EXEC_LD;
                end
                ST_EXEC: begin
                    if (!init_done_q && init_idx_q != INIT_LAST) begin
                        state_d    = ST_SETUP;
                        cnt_d      = SETUP_LD;
                        init_idx_d = init_idx_q + 2'd1;
                        lcd_rs_d   = 1'b0;
                        lcd_data_d = init_cmd(init_idx_q + 2'd1);
                    end else begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                end
                ST_IDLE: begin
                    // Buffered commands wait here until init has finished.
                    if (buf_full_q) begin
                        state_d    = ST_SETUP;
                        cnt_d      = SETUP_LD;
                        lcd_rs_d   = buf_rs_q;
                        lcd_data_d = buf_data_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_PWR_WAIT;
            cnt_q       <= PWR_LD;
            init_idx_q  <= 2'd0;
            init_done_q <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            lcd_on_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
            lcd_on_q    <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            buf_full_q <= 1'b0;
            buf_rs_q   <= 1'b0;
            buf_data_q <= 8'h00;
        end else if (push) begin
            buf_full_q <= 1'b1;
            buf_rs_q   <= i_cmd_rs;
            buf_data_q <= i_cmd_data;
        end else if (pop) begin
            buf_full_q <= 1'b0;
        end
    end

    // EN decodes straight from the state so an async reset kills it at once.
    assign o_cmd_ready = !buf_full_q;
    assign o_busy      = (state_q != ST_IDLE) || buf_full_q;
    assign o_init_done = init_done_q;
    assign o_lcd_on    = lcd_on_q;
    assign o_lcd_en    = (state_q == ST_PULSE);
    assign o_lcd_rs    = lcd_rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = lcd_data_q;
    assign o_dbg_state = state_q;

endmodule
